// File: rtl/queue_distributor_pkg.sv
// Shared defaults, FSM encoding and destination decode for the queue distributor.
// Latency and backpressure: no logic here; these are types and helpers only.
package queue_distributor_pkg;

  localparam int QD_QUEUE_QUANTITY = 4;
  localparam int QD_DATA_BITS      = 8;
  localparam int QD_CNT_BITS       = 16;

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_LOADED = 1'b1
  } state_t;

  // Destination queue index lives in the top sel_bits of the word.
  function automatic logic [31:0] dest_of(input logic [63:0] word,
                                          input int data_bits,
                                          input int sel_bits);
    logic [63:0] shifted;
    shifted = word >> (data_bits - sel_bits);
    return 32'(shifted & ((64'd1 << sel_bits) - 64'd1));
  endfunction

endpackage

// File: rtl/queue_distributor_if.sv
// Upstream handshake, FIFO write side and statistics of the queue distributor.
// Latency and backpressure: wires only; in_ready/buf_full carry the flow control.
interface queue_distributor_if
  import queue_distributor_pkg::*;
#(
  parameter int QUEUE_QUANTITY = QD_QUEUE_QUANTITY,
  parameter int DATA_BITS      = QD_DATA_BITS,
  parameter int CNT_BITS       = QD_CNT_BITS
);
  localparam int SEL_BITS = $clog2(QUEUE_QUANTITY);

  logic                      in_valid;
  logic [DATA_BITS-1:0]      in_data;
  logic                      in_ready;
  logic [QUEUE_QUANTITY-1:0] buf_full;
  logic [QUEUE_QUANTITY-1:0] push;
  logic [DATA_BITS-1:0]      push_data;
  logic [SEL_BITS-1:0]       selector;
  logic [CNT_BITS-1:0]       word_count;
  logic [CNT_BITS-1:0]       stall_count;

  modport master (
    output in_valid, in_data, buf_full,
    input  in_ready, push, push_data, selector, word_count, stall_count
  );

  modport slave (
    input  in_valid, in_data, buf_full,
    output in_ready, push, push_data, selector, word_count, stall_count
  );

endinterface

// File: rtl/queue_distributor_sat_counter.sv
// Saturating up-counter; value visible one cycle after an increment.
// No backpressure: increments are dropped once all-ones is reached, or while enb is low.
module queue_distributor_sat_counter #(
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enb,
  input  logic                inc,
  output logic [CNT_BITS-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (enb && inc && (count != {CNT_BITS{1'b1}})) begin
      count <= count + CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/queue_distributor.sv
// Steers each upstream word to the FIFO named by its top bits; push one cycle after accept.
// Backpressure: a full destination holds the word and drops in_ready; push+accept overlap at 1 word/cycle.
module queue_distributor
  import queue_distributor_pkg::*;
#(
  parameter int QUEUE_QUANTITY = QD_QUEUE_QUANTITY,
  parameter int DATA_BITS      = QD_DATA_BITS,
  parameter int CNT_BITS       = QD_CNT_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  queue_distributor_if.slave bus
);

  localparam int SEL_BITS = $clog2(QUEUE_QUANTITY);

  state_t                    state_q;
  state_t                    state_d;
  logic [DATA_BITS-1:0]      hold_data;
  logic [SEL_BITS-1:0]       hold_sel;
  logic                      fire;
  logic                      stall;
  logic                      in_ready_c;
  logic                      accept;
  logic [QUEUE_QUANTITY-1:0] push_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (enb) begin
      unique case (state_q)
        ST_EMPTY:  if (accept) state_d = ST_LOADED;
        ST_LOADED: if (fire && !accept) state_d = ST_EMPTY;
        default:   state_d = ST_EMPTY;
      endcase
    end
  end

  // Reset gates the strobes too, so nothing leaves the block during the reset cycle itself.
  always_comb begin
    fire       = 1'b0;
    stall      = 1'b0;
    push_c     = '0;
    in_ready_c = 1'b0;
    if (!rst && enb) begin
      if (state_q == ST_LOADED) begin
        if (bus.buf_full[hold_sel]) begin
          stall = 1'b1;
        end else begin
          fire   = 1'b1;
          push_c = QUEUE_QUANTITY'(1) << hold_sel;
        end
      end
      in_ready_c = (state_q == ST_EMPTY) || fire;
    end
  end

  assign accept = bus.in_valid && in_ready_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_data <= '0;
      hold_sel  <= '0;
    end else if (accept) begin
      hold_data <= bus.in_data;
      hold_sel  <= SEL_BITS'(dest_of(64'(bus.in_data), DATA_BITS, SEL_BITS));
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.push      = push_c;
  assign bus.push_data = hold_data;
  assign bus.selector  = hold_sel;

  queue_distributor_sat_counter #(.CNT_BITS(CNT_BITS)) u_word_cnt (
    .clk   (clk),
    .rst   (rst),
    .enb   (enb),
    .inc   (fire),
    .count (bus.word_count)
  );

  queue_distributor_sat_counter #(.CNT_BITS(CNT_BITS)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .enb   (enb),
    .inc   (stall),
    .count (bus.stall_count)
  );

  a_push_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.push));
  a_push_not_full: assert property (@(posedge clk) disable iff (rst) (bus.push & bus.buf_full) == '0);

endmodule

// File: tb/tb_queue_distributor.sv
// Directed plan plus random traffic on a 16-bit-counter and a 4-bit-counter build,
// both checked every cycle against a queue-based model of the distributor.
module tb_queue_distributor;

  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic       in_valid;
  logic [7:0] in_data;
  logic [3:0] buf_full;

  int n_checks = 0;
  int n_fail   = 0;
  bit run_chk  = 1'b0;

  always #5 clk = ~clk;

  queue_distributor_if #(.QUEUE_QUANTITY(4), .DATA_BITS(8), .CNT_BITS(16)) bus16 ();
  queue_distributor_if #(.QUEUE_QUANTITY(4), .DATA_BITS(8), .CNT_BITS(4))  bus4 ();

  assign bus16.in_valid = in_valid;
  assign bus16.in_data  = in_data;
  assign bus16.buf_full = buf_full;
  assign bus4.in_valid  = in_valid;
  assign bus4.in_data   = in_data;
  assign bus4.buf_full  = buf_full;

  queue_distributor #(.QUEUE_QUANTITY(4), .DATA_BITS(8), .CNT_BITS(16)) dut16 (
    .clk (clk), .rst (rst), .enb (enb), .bus (bus16)
  );
  queue_distributor #(.QUEUE_QUANTITY(4), .DATA_BITS(8), .CNT_BITS(4)) dut4 (
    .clk (clk), .rst (rst), .enb (enb), .bus (bus4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: words accepted but not yet pushed, the last accepted word, and the counters.
  logic [7:0] mq[$];
  logic [7:0] last_word = 8'h00;
  int wc16 = 0, wc4 = 0, sc16 = 0, sc4 = 0;

  always @(negedge clk) begin
    if (run_chk) begin
      logic [1:0] d;
      logic       can, stl, er;
      logic [3:0] ep;
      d   = last_word[7:6];
      can = !rst && enb && (mq.size() != 0) && !buf_full[d];
      stl = !rst && enb && (mq.size() != 0) && buf_full[d];
      er  = !rst && enb && ((mq.size() == 0) || can);
      ep  = 4'b0000;
      if (can) ep[d] = 1'b1;

      chk("push16", 32'(bus16.push), 32'(ep));
      chk("push4", 32'(bus4.push), 32'(ep));
      chk("in_ready16", 32'(bus16.in_ready), 32'(er));
      chk("in_ready4", 32'(bus4.in_ready), 32'(er));
      chk("push_data16", 32'(bus16.push_data), 32'(can ? mq[0] : last_word));
      chk("selector16", 32'(bus16.selector), 32'(d));
      chk("word_count16", 32'(bus16.word_count), 32'(wc16));
      chk("word_count4", 32'(bus4.word_count), 32'(wc4));
      chk("stall_count16", 32'(bus16.stall_count), 32'(sc16));
      chk("stall_count4", 32'(bus4.stall_count), 32'(sc4));

      if (rst) begin
        mq.delete();
        last_word = 8'h00;
        wc16 = 0; wc4 = 0; sc16 = 0; sc4 = 0;
      end else begin
        if (can) begin
          void'(mq.pop_front());
          if (wc16 < 65535) wc16++;
          if (wc4 < 15) wc4++;
        end
        if (stl) begin
          if (sc16 < 65535) sc16++;
          if (sc4 < 15) sc4++;
        end
        if (in_valid && er) begin
          mq.push_back(in_data);
          last_word = in_data;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic negc();
    @(negedge clk);
  endtask

  logic [7:0] w[4]   = '{8'h05, 8'h45, 8'h85, 8'hC5};
  logic [3:0] pat[4] = '{4'b0101, 4'b1100, 4'b1101, 4'b0100};

  initial begin
    rst = 1'b1; enb = 1'b1; in_valid = 1'b0; in_data = 8'h00; buf_full = 4'b0000;
    @(posedge clk);
    run_chk = 1'b1;
    #1;
    negc();
    chk("rst_push", 32'(bus16.push), 32'h0);
    chk("rst_in_ready", 32'(bus16.in_ready), 32'h0);
    chk("rst_push_data", 32'(bus16.push_data), 32'h0);
    chk("rst_word_count", 32'(bus16.word_count), 32'h0);
    tick();
    rst = 1'b0;

    // Back-to-back stream to all four queues.
    for (int i = 0; i < 5; i++) begin
      in_valid = (i < 4);
      if (i < 4) in_data = w[i];
      negc();
      chk("t1_in_ready", 32'(bus16.in_ready), 32'h1);
      if (i > 0) begin
        chk("t1_push", 32'(bus16.push), 32'(4'b0001 << (i - 1)));
        chk("t1_push_data", 32'(bus16.push_data), 32'(w[i-1]));
      end else begin
        chk("t1_push", 32'(bus16.push), 32'h0);
      end
      tick();
    end
    in_valid = 1'b0;
    negc();
    chk("t1_word_count", 32'(bus16.word_count), 32'd4);
    tick();

    // Held by a full destination for three cycles.
    buf_full = 4'b0100; in_valid = 1'b1; in_data = 8'h9A;
    negc();
    chk("t2_accept_rdy", 32'(bus16.in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      negc();
      chk("t2_stall_push", 32'(bus16.push), 32'h0);
      chk("t2_stall_rdy", 32'(bus16.in_ready), 32'h0);
      chk("t2_stall_count", 32'(bus16.stall_count), 32'(k));
      tick();
    end
    buf_full = 4'b0000;
    negc();
    chk("t2_release_push", 32'(bus16.push), 32'h4);
    chk("t2_release_data", 32'(bus16.push_data), 32'h9A);
    chk("t2_stall_total", 32'(bus16.stall_count), 32'd3);
    tick();

    // Other queues' full flags never release the held word.
    buf_full = 4'b0100; in_valid = 1'b1; in_data = 8'h9A;
    negc();
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      buf_full = pat[k];
      negc();
      chk("t3_no_push", 32'(bus16.push), 32'h0);
      tick();
    end
    buf_full = 4'b0001;
    negc();
    chk("t3_release", 32'(bus16.push), 32'h4);
    tick();
    buf_full = 4'b0000;
    negc();
    chk("t3_stall_total", 32'(bus16.stall_count), 32'd7);
    chk("t3_word_count", 32'(bus16.word_count), 32'd6);
    tick();

    // Enable low freezes a loaded word.
    in_valid = 1'b1; in_data = 8'h33;
    negc();
    tick();
    enb = 1'b0; in_data = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      negc();
      chk("t4_frozen_push", 32'(bus16.push), 32'h0);
      chk("t4_frozen_rdy", 32'(bus16.in_ready), 32'h0);
      tick();
    end
    enb = 1'b1; in_valid = 1'b0;
    negc();
    chk("t4_resume_push", 32'(bus16.push), 32'h1);
    chk("t4_resume_data", 32'(bus16.push_data), 32'h33);
    tick();

    // Reset while stalled discards the held word.
    buf_full = 4'b1000; in_valid = 1'b1; in_data = 8'hE1;
    negc();
    tick();
    in_valid = 1'b0;
    negc();
    chk("t5_stalled", 32'(bus16.push), 32'h0);
    tick();
    rst = 1'b1;
    negc();
    chk("t5_rst_push", 32'(bus16.push), 32'h0);
    chk("t5_rst_rdy", 32'(bus16.in_ready), 32'h0);
    tick();
    rst = 1'b0; buf_full = 4'b0000;
    negc();
    chk("t5_push", 32'(bus16.push), 32'h0);
    chk("t5_word_count", 32'(bus16.word_count), 32'h0);
    chk("t5_stall_count", 32'(bus16.stall_count), 32'h0);
    chk("t5_selector", 32'(bus16.selector), 32'h0);
    chk("t5_in_ready", 32'(bus16.in_ready), 32'h1);
    tick();

    // Sixteen pushes: the 4-bit counter pins at 0xF.
    for (int k = 0; k < 17; k++) begin
      in_valid = (k < 16);
      in_data  = 8'(k * 16 + 3);
      negc();
      tick();
    end
    in_valid = 1'b0;
    negc();
    chk("t6_sat4", 32'(bus4.word_count), 32'hF);
    chk("t6_count16", 32'(bus16.word_count), 32'd16);
    tick();

    for (int k = 0; k < 3000; k++) begin
      rst      = ($urandom_range(0, 199) == 0);
      enb      = ($urandom_range(0, 9) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      for (int b = 0; b < 4; b++) buf_full[b] = ($urandom_range(0, 2) == 0);
      negc();
      tick();
    end
    rst = 1'b0; enb = 1'b1; in_valid = 1'b0; buf_full = 4'b0000;
    negc();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/queue_distributor.md
Name: queue_distributor

Overview:
- Write-side counterpart of the round-robin queue reader.
- Accepts one data word per cycle from the upstream source over a valid/ready handshake.
- Decodes the destination queue from the word's top bits and issues a one-hot push to that queue's FIFO.
- Honours each FIFO's full flag by stalling upstream; never drops or corrupts a word.

Parameters:
- QUEUE_QUANTITY, 4: number of destination queues; power of 2, at least 2.
- DATA_BITS, 8: word width; must exceed SEL_BITS.
- CNT_BITS, 16: width of the statistics counters.
- SEL_BITS: localparam, $clog2(QUEUE_QUANTITY).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- enb  in  1  block enable; low freezes all state.
- in_valid  in  1  upstream word present.
- in_data  in  DATA_BITS  upstream word; destination = in_data[DATA_BITS-1 -: SEL_BITS].
- in_ready  out  1  block can take a word this cycle.
- buf_full  in  QUEUE_QUANTITY  per-queue FIFO full flags.
- push  out  QUEUE_QUANTITY  one-hot FIFO write strobes.
- push_data  out  DATA_BITS  word written to the selected FIFO.
- selector  out  SEL_BITS  destination index of the held word.
- word_count  out  CNT_BITS  total words pushed, saturating.
- stall_count  out  CNT_BITS  cycles a held word was blocked by full, saturating.

Behaviour:
- Storage: one hold register (hold_data, hold_sel) plus an FSM with states EMPTY and LOADED.
- push_data = hold_data and selector = hold_sel at all times.
- fire = enb & (state==LOADED) & ~buf_full[hold_sel].
  - push = fire ? (1 << hold_sel) : 0; combinational from registers and buf_full.
  - push is never more than one-hot; never asserted while buf_full[hold_sel]=1.
- in_ready = enb & ((state==EMPTY) | fire). This allows back-to-back transfers: push and accept in the same cycle.
- accept = in_valid & in_ready. On accept:
  - hold_data <= in_data.
  - hold_sel <= in_data top SEL_BITS.
  - state <= LOADED.
- FSM transitions (only when enb=1):
  - EMPTY: accept -> LOADED; otherwise stay.
  - LOADED: fire & accept -> LOADED with the new word; fire & ~accept -> EMPTY; ~fire -> stay, word retained.
- Latency: word accepted at edge N is pushed no earlier than the cycle after edge N. With an empty hold register and buf_full low, throughput is 1 word/cycle.
- Counters:
  - word_count += 1 on each fire.
  - stall_count += 1 each cycle with enb & LOADED & buf_full[hold_sel].
  - Both saturate at all-ones and do not wrap.
- enb=0:
  - in_ready=0 and push=0.
  - Hold register, state and counters are unchanged.
- Upstream is not required to hold in_data stable while in_ready=0; the block samples only on accept.
- Full flag changing while LOADED: the push fires in the first cycle buf_full[hold_sel]=0. Full flags of other queues are ignored.
- Reset, with priority over enb and all other inputs, including mid-stall:
  - state=EMPTY; hold_data=0; hold_sel=0.
  - Counters cleared.
  - Outputs: push=0, in_ready=0 during reset, push_data=0, selector=0.
  - The held word is discarded.

Decomposition:
- Shared package/header holds:
  - QUEUE_QUANTITY and DATA_BITS defaults.
  - EMPTY/LOADED state encoding, 1 bit.
  - A dest_of(word) function or macro extracting the top SEL_BITS.
- One natural sub-module: sat_counter (CNT_BITS, enb, inc, rst), instantiated twice.
- Verification follows the team's behavioural-versus-synthesized comparison pattern: a queue_distributorTester instantiates both models on shared stimulus and compares every output each cycle.

Test Plan (QUEUE_QUANTITY=4, DATA_BITS=8):
1. Reset, then stream 0x05, 0x45, 0x85, 0xC5 with buf_full=0 -> push = 0001, 0010, 0100, 1000 on consecutive cycles; push_data matches each word; in_ready stays 1; word_count=4.
2. buf_full=0100, send 0x9A -> held and LOADED; push=0; in_ready=0 and stall_count increments for 3 cycles; clear buf_full[2] -> push=0100 with push_data=0x9A; stall_count=3.
3. Hold 0x9A blocked, toggle buf_full[0] and buf_full[3] -> no push; only buf_full[2] releases it.
4. Drive enb=0 for 2 cycles while LOADED and buf_full=0 -> push=0 and in_ready=0; word is pushed on the first enb=1 cycle.
5. Assert rst while LOADED and stalled -> next cycle: state EMPTY, counters 0, push=0; the stale word is never pushed.
6. Preload word_count to all-ones (CNT_BITS=4 build, 15 pushes) then push once more -> word_count stays 0xF.
